// File: rtl/trig_cmd_sequencer.sv
// Purpose: decodes a UART byte command stream into trigger register writes and reads; read bytes go back out on tx.
// Latency: write strobe one clock after each data byte; read strobe then tx_valid on the next clock, so one byte per 2 clocks.
// Backpressure: tx_valid/tx_data hold until tx_ready; rx bytes have no backpressure and are dropped during reads.
module trig_cmd_sequencer #(
    parameter int NUM_REGS       = 9,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n_sync,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] address,
    output logic       trigger_write_enable,
    output logic [7:0] write_data_out,
    output logic       trigger_read_enable,
    input  logic [7:0] trigger_read_data,
    output logic       busy
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_LEN  = 3'd1,
        WR_DATA  = 3'd2,
        RD_ISSUE = 3'd3,
        RD_SEND  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       count_q, count_d;
    logic             rnw_q, rnw_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             wr_en_q, wr_en_d;
    logic             rd_en_q, rd_en_d;
    logic             wr_pend_q, wr_pend_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             busy_q, busy_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic wr_take;
    logic tmo_expired;
    logic timed_q, timed_d;

    function automatic logic in_range(input logic [7:0] a);
        return ({24'd0, a} < 32'(NUM_REGS));
    endfunction

    assign tmo_expired = (tmo_q == TMO_LAST);
    assign timed_q     = (state_q == GET_LEN) || (state_q == WR_DATA);
    assign timed_d     = (state_d == GET_LEN) || (state_d == WR_DATA);

    // Next-state and registered-output computation; address/count advance one clock after a written byte
    // (wr_pend_q) so the strobe is presented with the address it targets.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        rnw_d      = rnw_q;
        wdata_d    = wdata_q;
        wr_pend_d  = 1'b0;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        wr_take    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    rnw_d   = rx_data[7];
                    addr_d  = {1'b0, rx_data[6:0]};
                    state_d = GET_LEN;
                end
            end
            GET_LEN: begin
                if (rx_valid) begin
                    count_d = rx_data;
                    if (rx_data == 8'd0)  state_d = IDLE;
                    else if (rnw_q)       state_d = RD_ISSUE;
                    else                  state_d = WR_DATA;
                end else if (tmo_expired) begin
                    state_d = IDLE;
                end
            end
            WR_DATA: begin
                if (wr_pend_q) begin
                    addr_d  = addr_q + 8'd1;
                    count_d = count_q - 8'd1;
                    if (count_q == 8'd1) state_d = IDLE;
                end
                // A byte landing on the final pointer update has no slot left in this command and is dropped.
                if (rx_valid && (state_d == WR_DATA)) begin
                    wr_take   = 1'b1;
                    wdata_d   = rx_data;
                    wr_pend_d = 1'b1;
                end else if (!wr_pend_q && !rx_valid && tmo_expired) begin
                    state_d = IDLE;
                end
            end
            RD_ISSUE: begin
                // Out-of-range reads issue no strobe and return zero.
                tx_data_d  = rd_en_q ? trigger_read_data : 8'h00;
                tx_valid_d = 1'b1;
                state_d    = RD_SEND;
            end
            RD_SEND: begin
                if (tx_valid_q && tx_ready) begin
                    tx_valid_d = 1'b0;
                    addr_d     = addr_q + 8'd1;
                    count_d    = count_q - 8'd1;
                    state_d    = (count_q == 8'd1) ? IDLE : RD_ISSUE;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        wr_en_d = wr_take && in_range(addr_d);
        rd_en_d = (state_d == RD_ISSUE) && in_range(addr_d);
        busy_d  = (state_d != IDLE);

        if (rx_valid || !timed_q || !timed_d) tmo_d = '0;
        else                                  tmo_d = tmo_q + TMO_W'(1);
    end

    // State and output registers; reset aborts any command in flight.
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q    <= IDLE;
            addr_q     <= 8'h00;
            count_q    <= 8'h00;
            rnw_q      <= 1'b0;
            wdata_q    <= 8'h00;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_pend_q  <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            rnw_q      <= rnw_d;
            wdata_q    <= wdata_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            wr_pend_q  <= wr_pend_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            tmo_q      <= tmo_d;
        end
    end

    assign address              = addr_q;
    assign write_data_out       = wdata_q;
    assign trigger_write_enable = wr_en_q;
    assign trigger_read_enable  = rd_en_q;
    assign tx_data              = tx_data_q;
    assign tx_valid             = tx_valid_q;
    assign busy                 = busy_q;

endmodule

// File: doc/trig_cmd_sequencer.md
TRIG_CMD_SEQUENCER -- requirements
Module: trig_cmd_sequencer

Interface
REQ-001 Parameter NUM_REGS, default 9, number of implemented trigger config addresses (0..NUM_REGS-1).
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, maximum idle clocks between received bytes within a command.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n_sync  input  1  reset, asynchronous, active-low.
REQ-005 rx_data  input  8  received UART byte.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data valid.
REQ-007 tx_data  output  8  byte to transmit.
REQ-008 tx_valid  output  1  tx_data valid; held until accepted.
REQ-009 tx_ready  input  1  transmitter accepts; transfer occurs when tx_valid && tx_ready.
REQ-010 address  output  8  register map address.
REQ-011 trigger_write_enable  output  1  one-cycle register write strobe.
REQ-012 write_data_out  output  8  register write data, valid with trigger_write_enable.
REQ-013 trigger_read_enable  output  1  one-cycle register read strobe.
REQ-014 trigger_read_data  input  8  combinational read data, valid in the same cycle as trigger_read_enable.
REQ-015 busy  output  1  high whenever state != IDLE.

Function
REQ-016 Command framing: byte0 = {rnw, addr[6:0]}; byte1 = count N (0..255); write: N data bytes follow; read: sequencer returns N bytes on tx.
REQ-017 States: IDLE, GET_LEN, WR_DATA, RD_ISSUE, RD_SEND.
REQ-018 IDLE: on rx_valid, latch rnw, load address = {1'b0, rx_data[6:0]}, go to GET_LEN.
REQ-019 GET_LEN: on rx_valid, load count; count == 0 -> IDLE; else rnw=0 -> WR_DATA, rnw=1 -> RD_ISSUE.
REQ-020 WR_DATA: each rx_valid -> the next cycle drives trigger_write_enable=1 for exactly one cycle with write_data_out = that byte at the current address; then address += 1 and count -= 1; count reaching 0 -> IDLE.
REQ-021 RD_ISSUE: trigger_read_enable=1 for exactly one cycle; capture trigger_read_data into tx_data that cycle; next state RD_SEND.
REQ-022 RD_SEND: tx_valid=1, tx_data stable until tx_valid && tx_ready; in that cycle address += 1, count -= 1; count reaching 0 -> IDLE, else RD_ISSUE.
REQ-023 Minimum read throughput: one byte per 2 clocks when tx_ready is held high.
REQ-024 Address out of range (address >= NUM_REGS): the write strobe is suppressed, the byte is still consumed, and count still decrements; the read strobe is suppressed and tx_data = 8'h00.
REQ-025 Address increments as 8-bit wrap-around (8'hFF + 1 = 8'h00); the wrapped address is subject to REQ-024.
REQ-026 trigger_write_enable and trigger_read_enable are never high in the same cycle.
REQ-027 rx_valid in RD_ISSUE or RD_SEND is ignored and dropped.
REQ-028 Timeout: a counter clears on every rx_valid and on entry to GET_LEN/WR_DATA. It increments in GET_LEN and WR_DATA. When it reaches TIMEOUT_CYCLES, the state returns to IDLE with no strobe. The counter does not run in read states.
REQ-029 A timeout in the same cycle as rx_valid: rx_valid wins; the byte is processed and the counter clears.
REQ-030 All outputs are registered; write/read strobes and address change only on clk rising edges.

Reset
REQ-031 While rst_n_sync=0 and immediately after, the outputs are: state=IDLE, address=8'h00, write_data_out=8'h00, tx_data=8'h00, tx_valid=0, trigger_write_enable=0, trigger_read_enable=0, busy=0, count=0, and the timeout counter=0.
REQ-032 Reset asserted mid-command (including tx_valid high in RD_SEND) aborts it immediately; no strobe is issued after reset deasserts until a new command arrives.

Verification
REQ-033 Bytes 0x04,0x02,0xAA,0x55 -> write strobes at address 4 with data 0xAA, then at address 5 with data 0x55; busy falls after the second strobe.
REQ-034 Bytes 0x80,0x09 with registers preloaded and tx_ready=1 -> 9 read strobes at addresses 0..8; tx returns 9 bytes matching the register contents, at one byte per 2 clocks.
REQ-035 Bytes 0x88,0x03 -> read at address 8 returns the real value; addresses 9 and 10 produce no strobe and return 0x00; state returns to IDLE.
REQ-036 Read with tx_ready held low for 20 clocks -> tx_valid and tx_data stay stable; no extra read strobe; resumes when tx_ready=1.
REQ-037 TIMEOUT_CYCLES=16; send 0x01 then nothing -> return to IDLE after 16 clocks; next bytes 0x01,0x01,0x07 -> one write to address 1 with data 0x07.
REQ-038 Assert rst_n_sync mid-write after 1 of 3 data bytes -> all outputs at reset values; a subsequent fresh command executes correctly.
